// File: rtl/usrt_xfer_ctrl_if.sv
// APB-side bus bundle for the USRT transfer controller.
interface usrt_xfer_ctrl_if;
    logic       pSelect;
    logic       pEnable;
    logic       pWrite;
    logic       pAddr;
    logic [7:0] pWData;
    logic [7:0] pRData;
    logic       pReady;
    logic       pSlvErr;

    modport master (
        output pSelect, pEnable, pWrite, pAddr, pWData,
        input  pRData, pReady, pSlvErr
    );

    modport slave (
        input  pSelect, pEnable, pWrite, pAddr, pWData,
        output pRData, pReady, pSlvErr
    );
endinterface

// File: rtl/usrt_xfer_ctrl.sv
// USRT transfer controller: one 11-bit half-duplex frame per APB DATA access,
// wait-stated until the frame completes, with sticky error status.
module usrt_xfer_ctrl #(
    parameter int BAUD_DIV   = 80,
    parameter int RX_TIMEOUT = 32
) (
    input  logic            pClk,
    input  logic            pReset,
    usrt_xfer_ctrl_if.slave apb,
    output logic            uClk,
    output logic            dir,
    output logic            txLine,
    input  logic            rxLine
);
    localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int TW = $clog2(RX_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(BAUD_DIV - 1);
    localparam logic [TW-1:0] TMO_MAX = TW'(RX_TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, TX, HUNT, RX, DONE} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [3:0]    idx, idx_nxt;
    logic [TW-1:0] tmo, tmo_nxt;
    logic [7:0]    dat, dat_nxt;
    logic [7:0]    rdata, rdata_nxt;
    logic [2:0]    status, status_nxt;   // {tmo_err, stop_err, par_err}
    logic [2:0]    pend, pend_nxt;       // errors of the transfer in flight
    logic [2:0]    err_set;
    logic          clr;
    logic          ready, ready_nxt;
    logic          slverr, slverr_nxt;
    logic          dir_nxt, tx_nxt;
    logic          tick, accept, abort;
    logic [10:0]   frame;

    assign tick   = (state != IDLE) && (cnt == CNT_MAX);
    // ready high means the master is still in the completing access phase
    assign accept = (state == IDLE) && apb.pSelect && apb.pEnable && !ready;
    assign abort  = (state != IDLE) && !apb.pSelect;
    assign frame  = {1'b0, ^dat, dat, 1'b1};

    assign uClk        = tick;
    assign apb.pReady  = ready;
    assign apb.pSlvErr = slverr;
    assign apb.pRData  = rdata;

    always_ff @(posedge pClk) begin
        if (pReset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept && !apb.pAddr) state_nxt = apb.pWrite ? TX : HUNT;
            TX:   if (tick && idx == 4'd10) state_nxt = DONE;
            HUNT: if (tick) begin
                      if (rxLine)              state_nxt = RX;
                      else if (tmo == TMO_MAX) state_nxt = DONE;
                  end
            RX:   if (tick && idx == 4'd10) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (abort) state_nxt = IDLE;
    end

    always_comb begin
        cnt_nxt    = (state == IDLE || tick) ? '0 : cnt + 1'b1;
        idx_nxt    = idx;
        tmo_nxt    = tmo;
        dat_nxt    = dat;
        pend_nxt   = pend;
        rdata_nxt  = rdata;
        ready_nxt  = 1'b0;
        slverr_nxt = 1'b0;
        dir_nxt    = dir;
        tx_nxt     = txLine;
        err_set    = '0;
        clr        = 1'b0;
        case (state)
            IDLE: if (accept) begin
                if (apb.pAddr) begin
                    ready_nxt  = 1'b1;
                    slverr_nxt = apb.pWrite;
                    if (!apb.pWrite) begin
                        rdata_nxt = {5'b0, status};
                        clr       = 1'b1;
                    end
                end else begin
                    idx_nxt  = '0;
                    tmo_nxt  = '0;
                    pend_nxt = '0;
                    dir_nxt  = apb.pWrite;
                    tx_nxt   = apb.pWrite;
                    if (apb.pWrite) dat_nxt = apb.pWData;
                end
            end
            TX: if (tick) begin
                if (idx == 4'd10) begin
                    tx_nxt    = 1'b0;
                    dir_nxt   = 1'b0;
                    ready_nxt = 1'b1;
                end else begin
                    idx_nxt = idx + 4'd1;
                    tx_nxt  = frame[idx + 4'd1];
                end
            end
            HUNT: if (tick) begin
                if (rxLine) begin
                    idx_nxt = 4'd1;
                end else if (tmo == TMO_MAX) begin
                    err_set    = 3'b100;
                    ready_nxt  = 1'b1;
                    slverr_nxt = 1'b1;
                    rdata_nxt  = '0;
                end else begin
                    tmo_nxt = tmo + 1'b1;
                end
            end
            RX: if (tick) begin
                idx_nxt = idx + 4'd1;
                if (idx <= 4'd8) dat_nxt = {rxLine, dat[7:1]};
                if (idx == 4'd9 && rxLine != ^dat) pend_nxt[0] = 1'b1;
                // errors reach the sticky register only when the frame completes
                if (idx == 4'd10) begin
                    err_set    = pend | {1'b0, rxLine, 1'b0};
                    ready_nxt  = 1'b1;
                    slverr_nxt = |err_set;
                    rdata_nxt  = (|err_set) ? 8'h00 : dat;
                end
            end
            DONE: dat_nxt = '0;
            default: ;
        endcase
        if (abort) begin
            ready_nxt  = 1'b0;
            slverr_nxt = 1'b0;
            tx_nxt     = 1'b0;
            dir_nxt    = 1'b0;
            dat_nxt    = '0;
            err_set    = '0;
            rdata_nxt  = rdata;
        end
        status_nxt = (clr ? 3'b000 : status) | err_set;
    end

    always_ff @(posedge pClk) begin
        if (pReset) begin
            cnt    <= '0;
            idx    <= '0;
            tmo    <= '0;
            dat    <= '0;
            pend   <= '0;
            status <= '0;
            rdata  <= '0;
            ready  <= 1'b0;
            slverr <= 1'b0;
            dir    <= 1'b0;
            txLine <= 1'b0;
        end else begin
            cnt    <= cnt_nxt;
            idx    <= idx_nxt;
            tmo    <= tmo_nxt;
            dat    <= dat_nxt;
            pend   <= pend_nxt;
            status <= status_nxt;
            rdata  <= rdata_nxt;
            ready  <= ready_nxt;
            slverr <= slverr_nxt;
            dir    <= dir_nxt;
            txLine <= tx_nxt;
        end
    end
endmodule

// File: tb/tb_usrt_xfer_ctrl.sv
// Directed bench for usrt_xfer_ctrl with BAUD_DIV=4, RX_TIMEOUT=3.
module tb_usrt_xfer_ctrl;
    localparam int B = 4;

    logic pClk, pReset, uClk, dir, txLine, rxLine;
    usrt_xfer_ctrl_if bus();

    usrt_xfer_ctrl #(.BAUD_DIV(B), .RX_TIMEOUT(3)) dut (
        .pClk(pClk), .pReset(pReset), .apb(bus),
        .uClk(uClk), .dir(dir), .txLine(txLine), .rxLine(rxLine)
    );

    initial pClk = 1'b0;
    always #5 pClk = ~pClk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic setup(input logic wr, input logic adr, input logic [7:0] wd);
        @(posedge pClk); #1;
        bus.pSelect = 1'b1; bus.pEnable = 1'b0;
        bus.pWrite = wr; bus.pAddr = adr; bus.pWData = wd;
        @(posedge pClk); #1;
        bus.pEnable = 1'b1;
    endtask

    // lat counts cycles from access-phase start to the cycle showing pReady
    task automatic xfer(input logic wr, input logic adr, input logic [7:0] wd,
                        input logic [10:0] rxf, output logic [7:0] rd,
                        output logic err, output int lat, output logic [10:0] txs);
        rd = 'x; err = 'x; lat = -1; txs = '0;
        setup(wr, adr, wd);
        for (int n = 1; n <= 200; n++) begin
            @(posedge pClk); #1;
            rxLine = (n <= 11*B) ? rxf[(n-1)/B] : 1'b0;
            if ((n-1) % B == 1 && n <= 11*B) txs[(n-1)/B] = txLine;
            if (bus.pReady) begin
                rd = bus.pRData; err = bus.pSlvErr; lat = n;
                break;
            end
        end
        bus.pSelect = 1'b0; bus.pEnable = 1'b0; rxLine = 1'b0;
    endtask

    logic [7:0]  rd;
    logic        err;
    int          lat;
    logic [10:0] txs;
    logic [10:0] frm_ok, frm_par;
    logic        seen_rdy, seen_clk;

    initial begin
        pReset = 1'b1; rxLine = 1'b0;
        bus.pSelect = 1'b0; bus.pEnable = 1'b0; bus.pWrite = 1'b0;
        bus.pAddr = 1'b0; bus.pWData = 8'h00;
        repeat (3) @(posedge pClk);
        #1;
        chk("rst_rdata",  bus.pRData,  8'h00);
        chk("rst_ready",  bus.pReady,  1'b0);
        chk("rst_slverr", bus.pSlvErr, 1'b0);
        chk("rst_uclk",   uClk,        1'b0);
        chk("rst_dir",    dir,         1'b0);
        chk("rst_tx",     txLine,      1'b0);
        pReset = 1'b0;

        // write A5: frame periods 1,1,0,1,0,0,1,0,1,0,0 (bit 0 first)
        xfer(1'b1, 1'b0, 8'hA5, 11'b0, rd, err, lat, txs);
        chk("wr_lat",   lat, 45);
        chk("wr_err",   err, 1'b0);
        chk("wr_frame", txs, 11'b00101001011);
        chk("wr_dir",   dir, 1'b0);

        // read 3C: start, LSB-first data, parity 0, stop 0
        frm_ok  = {1'b0, 1'b0, 8'h3C, 1'b1};
        frm_par = {1'b0, 1'b1, 8'h3C, 1'b1};
        xfer(1'b0, 1'b0, 8'h00, frm_ok, rd, err, lat, txs);
        chk("rd_data", rd,  8'h3C);
        chk("rd_err",  err, 1'b0);
        chk("rd_lat",  lat, 45);
        xfer(1'b0, 1'b1, 8'h00, 11'b0, rd, err, lat, txs);
        chk("st_clean", rd,  8'h00);
        chk("st_lat",   lat, 1);

        // parity flipped
        xfer(1'b0, 1'b0, 8'h00, frm_par, rd, err, lat, txs);
        chk("par_data", rd,  8'h00);
        chk("par_err",  err, 1'b1);
        xfer(1'b0, 1'b1, 8'h00, 11'b0, rd, err, lat, txs);
        chk("par_st1", rd, 8'h01);
        chk("par_st1_err", err, 1'b0);
        xfer(1'b0, 1'b1, 8'h00, 11'b0, rd, err, lat, txs);
        chk("par_st2", rd, 8'h00);

        // no start bit: timeout after 3 ticks
        xfer(1'b0, 1'b0, 8'h00, 11'b0, rd, err, lat, txs);
        chk("tmo_lat",  lat, 13);
        chk("tmo_err",  err, 1'b1);
        chk("tmo_data", rd,  8'h00);
        xfer(1'b0, 1'b1, 8'h00, 11'b0, rd, err, lat, txs);
        chk("tmo_st", rd, 8'h04);

        // abort at the first HUNT tick
        setup(1'b0, 1'b0, 8'h00);
        seen_rdy = 1'b0; seen_clk = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge pClk); #1;
            if (n == B) begin bus.pSelect = 1'b0; bus.pEnable = 1'b0; end
            if (bus.pReady) seen_rdy = 1'b1;
            if (n > B && uClk) seen_clk = 1'b1;
        end
        chk("abort_rdy",  seen_rdy, 1'b0);
        chk("abort_uclk", seen_clk, 1'b0);
        chk("abort_dir",  dir,      1'b0);
        xfer(1'b1, 1'b1, 8'h55, 11'b0, rd, err, lat, txs);
        chk("stwr_err", err, 1'b1);
        chk("stwr_lat", lat, 1);
        xfer(1'b0, 1'b1, 8'h00, 11'b0, rd, err, lat, txs);
        chk("abort_st", rd, 8'h00);

        // reset mid-TX during bit 4 (d[3]=1 for 0F)
        setup(1'b1, 1'b0, 8'h0F);
        for (int n = 1; n <= 18; n++) begin
            @(posedge pClk); #1;
        end
        chk("pre_rst_tx",  txLine, 1'b1);
        chk("pre_rst_dir", dir,    1'b1);
        pReset = 1'b1;
        @(posedge pClk); #1;
        chk("mid_rst_tx",   txLine,     1'b0);
        chk("mid_rst_dir",  dir,        1'b0);
        chk("mid_rst_uclk", uClk,       1'b0);
        chk("mid_rst_rdy",  bus.pReady, 1'b0);
        pReset = 1'b0; bus.pSelect = 1'b0; bus.pEnable = 1'b0;
        seen_rdy = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(posedge pClk); #1;
            if (bus.pReady) seen_rdy = 1'b1;
        end
        chk("post_rst_rdy", seen_rdy, 1'b0);
        xfer(1'b1, 1'b0, 8'h81, 11'b0, rd, err, lat, txs);
        chk("post_wr_lat",   lat, 45);
        chk("post_wr_err",   err, 1'b0);
        chk("post_wr_frame", txs, 11'b00100000011);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
